// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Requester, response and ALU-side bus for alu_arbiter.
//                Requester k occupies slice k of each packed request vector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 31
);
  // Requester channels
  logic [1:0]                  i_req_valid;
  logic [1:0]                  o_req_ready;
  logic [33:0]                 i_req_op;
  logic [2*(DATA_WIDTH+1)-1:0] i_req_rs1;
  logic [2*(DATA_WIDTH+1)-1:0] i_req_rs2;
  logic [63:0]                 i_req_imm;

  // Shared tagged response channel
  logic                        o_rsp_valid;
  logic                        o_rsp_id;
  logic [DATA_WIDTH:0]         o_rsp_data;
  logic                        i_rsp_ready;

  // ALU side
  logic [16:0]                 o_alu_op;
  logic [DATA_WIDTH:0]         o_alu_rs1;
  logic [DATA_WIDTH:0]         o_alu_rs2;
  logic [31:0]                 o_alu_imm;
  logic [DATA_WIDTH:0]         i_alu_rd_data;

  // Arbiter view
  modport slave (
    input  i_req_valid, i_req_op, i_req_rs1, i_req_rs2, i_req_imm,
    input  i_rsp_ready, i_alu_rd_data,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data,
    output o_alu_op, o_alu_rs1, o_alu_rs2, o_alu_imm
  );

  // Requester / consumer / ALU view
  modport master (
    output i_req_valid, i_req_op, i_req_rs1, i_req_rs2, i_req_imm,
    output i_rsp_ready, i_alu_rd_data,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data,
    input  o_alu_op, o_alu_rs1, o_alu_rs2, o_alu_imm
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one combinational ALU between two
//                requesters. The granted operation is latched into an operand
//                register driving the ALU, the result is captured one cycle
//                later and returned on a tagged response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_WIDTH = 31
) (
  input  wire logic    clk,
  input  wire logic    clk_en,
  input  wire logic    rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic                last_grant;
  logic                grant_idx;
  logic                can_accept;
  logic                accept;
  logic [1:0]          req_ready;

  logic [16:0]         op_q;
  logic [DATA_WIDTH:0] rs1_q;
  logic [DATA_WIDTH:0] rs2_q;
  logic [31:0]         imm_q;
  logic                id_q;
  logic [DATA_WIDTH:0] result_q;

  logic [16:0]         sel_op;
  logic [DATA_WIDTH:0] sel_rs1;
  logic [DATA_WIDTH:0] sel_rs2;
  logic [31:0]         sel_imm;

  // Arbitration, handshake and next-state decode
  always_comb begin
    next_state = state;
    grant_idx  = 1'b0;
    can_accept = 1'b0;
    accept     = 1'b0;
    req_ready  = 2'b00;

    // A tie goes to whoever did not win the last accepted handshake
    case (bus.i_req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase

    // New work can be taken when idle, or when the held result leaves now
    if (clk_en && !rst) begin
      case (state)
        IDLE:    can_accept = 1'b1;
        RESP:    can_accept = bus.i_rsp_ready;
        default: can_accept = 1'b0;
      endcase
    end

    if (can_accept && (bus.i_req_valid != 2'b00)) begin
      accept    = 1'b1;
      req_ready = grant_idx ? 2'b10 : 2'b01;
    end

    if (clk_en) begin
      case (state)
        IDLE: if (accept) next_state = EXEC;
        EXEC: next_state = RESP;
        RESP: if (bus.i_rsp_ready) next_state = accept ? EXEC : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Slice out the granted requester's operation
  always_comb begin
    sel_op  = grant_idx ? bus.i_req_op[33:17]  : bus.i_req_op[16:0];
    sel_rs1 = grant_idx ? bus.i_req_rs1[DATA_WIDTH+1 +: DATA_WIDTH+1]
                        : bus.i_req_rs1[0 +: DATA_WIDTH+1];
    sel_rs2 = grant_idx ? bus.i_req_rs2[DATA_WIDTH+1 +: DATA_WIDTH+1]
                        : bus.i_req_rs2[0 +: DATA_WIDTH+1];
    sel_imm = grant_idx ? bus.i_req_imm[63:32] : bus.i_req_imm[31:0];
  end

  // State register; clk_en gating already lives in next_state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand register, owner id and round-robin pointer, loaded on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_q       <= sel_op;
      rs1_q      <= sel_rs1;
      rs2_q      <= sel_rs2;
      imm_q      <= sel_imm;
      id_q       <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  // Capture the ALU result after its single evaluation cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (clk_en && (state == EXEC)) begin
      result_q <= bus.i_alu_rd_data;
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = (state == RESP);
  assign bus.o_rsp_id    = id_q;
  assign bus.o_rsp_data  = result_q;
  assign bus.o_alu_op    = op_q;
  assign bus.o_alu_rs1   = rs1_q;
  assign bus.o_alu_rs2   = rs2_q;
  assign bus.o_alu_imm   = imm_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Scoreboard bench for alu_arbiter with a small behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam logic [16:0] OP_ADD  = {7'b0110011, 7'b0000000, 3'b000};
  localparam logic [16:0] OP_SUB  = {7'b0110011, 7'b0100000, 3'b000};
  localparam logic [16:0] OP_SRAI = {7'b0010011, 7'b0100000, 3'b101};
  localparam logic [16:0] OP_ADDI = {7'b0010011, 7'b0000000, 3'b000};

  logic clk = 1'b0;
  logic clk_en;
  logic rst;
  int   cyc = 0;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  bit          gap_chk = 1'b0;
  bit          have_prev = 1'b0;
  int          prev_cyc = 0;

  alu_arbiter_if #(.DATA_WIDTH(31)) bus ();

  alu_arbiter #(.DATA_WIDTH(31)) dut (
    .clk    (clk),
    .clk_en (clk_en),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: unknown encodings return 0
  function automatic logic [31:0] alu(input logic [16:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] imm);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_ADDI: return a + imm;
      OP_SRAI: return $unsigned($signed(a) >>> imm[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.i_alu_rd_data = alu(bus.o_alu_op, bus.o_alu_rs1, bus.o_alu_rs2, bus.o_alu_imm);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [16:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
    bus.i_req_op[17*k +: 17]  = op;
    bus.i_req_rs1[32*k +: 32] = a;
    bus.i_req_rs2[32*k +: 32] = b;
    bus.i_req_imm[32*k +: 32] = imm;
  endtask

  // Monitor: every accepted response is popped and compared
  always @(negedge clk) begin
    if (!rst && clk_en && bus.o_rsp_valid && bus.i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual id=%0d data=0x%0h required=none",
                 bus.o_rsp_id, bus.o_rsp_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_id", {63'd0, bus.o_rsp_id}, {63'd0, e[32]});
        check("rsp_data", {32'd0, bus.o_rsp_data}, {32'd0, e[31:0]});
      end
      if (gap_chk) begin
        if (have_prev) check("rsp_gap", 64'(cyc - prev_cyc), 64'd2);
        have_prev = 1'b1;
        prev_cyc  = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    clk_en = 1'b1;
    bus.i_req_valid = 2'b00;
    bus.i_req_op = '0;
    bus.i_req_rs1 = '0;
    bus.i_req_rs2 = '0;
    bus.i_req_imm = '0;
    bus.i_rsp_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req_ready", {62'd0, bus.o_req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd0);
    check("rst_rsp_data", {32'd0, bus.o_rsp_data}, 64'd0);
    check("rst_alu_op", {47'd0, bus.o_alu_op}, 64'd0);
    rst = 1'b0;

    // Single requester ADD 5+7
    set_req(0, OP_ADD, 32'd5, 32'd7, 32'd0);
    bus.i_req_valid = 2'b01;
    bus.i_rsp_ready = 1'b1;
    #1 check("t1_ready", {62'd0, bus.o_req_ready}, 64'd1);
    exp_q.push_back({1'b0, 32'd12});
    tick();
    bus.i_req_valid = 2'b00;
    #1;
    check("t1_exec_ready", {62'd0, bus.o_req_ready}, 64'd0);
    check("t1_exec_valid", {63'd0, bus.o_rsp_valid}, 64'd0);
    check("t1_alu_op", {47'd0, bus.o_alu_op}, {47'd0, OP_ADD});
    check("t1_alu_rs1", {32'd0, bus.o_alu_rs1}, 64'd5);
    check("t1_alu_rs2", {32'd0, bus.o_alu_rs2}, 64'd7);
    tick();
    check("t1_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd1);
    tick();
    check("t1_idle", {63'd0, bus.o_rsp_valid}, 64'd0);

    // Tie after reset: req0 SUB first, then req1 SRAI
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, OP_SUB, 32'd10, 32'd3, 32'd0);
    set_req(1, OP_SRAI, 32'h8000_0000, 32'd0, 32'd4);
    bus.i_req_valid = 2'b11;
    #1 check("t2_ready0", {62'd0, bus.o_req_ready}, 64'd1);
    exp_q.push_back({1'b0, 32'd7});
    exp_q.push_back({1'b1, 32'hF800_0000});
    tick();
    check("t2_exec_ready", {62'd0, bus.o_req_ready}, 64'd0);
    tick();
    check("t2_ready1", {62'd0, bus.o_req_ready}, 64'd2);
    tick();
    bus.i_req_valid = 2'b00;
    tick();
    tick();

    // Backpressure while both requesters wait
    set_req(0, OP_ADD, 32'd100, 32'd23, 32'd0);
    set_req(1, OP_ADD, 32'd1, 32'd2, 32'd0);
    bus.i_req_valid = 2'b11;
    bus.i_rsp_ready = 1'b0;
    #1 check("t3_ready0", {62'd0, bus.o_req_ready}, 64'd1);
    exp_q.push_back({1'b0, 32'd123});
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {63'd0, bus.o_rsp_valid}, 64'd1);
      check("t3_hold_data", {32'd0, bus.o_rsp_data}, 64'd123);
      check("t3_hold_id", {63'd0, bus.o_rsp_id}, 64'd0);
      check("t3_hold_ready", {62'd0, bus.o_req_ready}, 64'd0);
      tick();
    end
    bus.i_rsp_ready = 1'b1;
    #1 check("t3_resume_ready", {62'd0, bus.o_req_ready}, 64'd2);
    exp_q.push_back({1'b1, 32'd3});
    tick();
    bus.i_req_valid = 2'b00;
    tick();
    tick();

    // Sustained contention: 20 ops alternating, one response per 2 cycles
    set_req(0, OP_ADD, 32'h11, 32'h22, 32'd0);
    set_req(1, OP_ADDI, 32'h100, 32'd0, 32'd5);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({1'b0, 32'h33});
      exp_q.push_back({1'b1, 32'h105});
    end
    have_prev = 1'b0;
    gap_chk = 1'b1;
    bus.i_req_valid = 2'b11;
    n = 0;
    for (int k = 0; k < 100 && n < 20; k++) begin
      #1;
      if (bus.o_req_ready != 2'b00) n++;
      tick();
      if (n == 20) bus.i_req_valid = 2'b00;
    end
    check("t4_accepts", 64'(n), 64'd20);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    tick();
    gap_chk = 1'b0;
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // Clock enable low while in EXEC
    set_req(0, OP_ADD, 32'd3, 32'd4, 32'd0);
    bus.i_req_valid = 2'b01;
    bus.i_rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'd7});
    tick();
    clk_en = 1'b0;
    bus.i_req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_frz_valid", {63'd0, bus.o_rsp_valid}, 64'd0);
      check("t5_frz_ready", {62'd0, bus.o_req_ready}, 64'd0);
      check("t5_frz_rs1", {32'd0, bus.o_alu_rs1}, 64'd3);
      tick();
    end
    clk_en = 1'b1;
    bus.i_req_valid = 2'b00;
    tick();
    check("t5_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd1);
    check("t5_rsp_data", {32'd0, bus.o_rsp_data}, 64'd7);
    clk_en = 1'b0;
    bus.i_rsp_ready = 1'b1;
    tick();
    tick();
    check("t5_rsp_held", {63'd0, bus.o_rsp_valid}, 64'd1);
    check("t5_data_held", {32'd0, bus.o_rsp_data}, 64'd7);
    clk_en = 1'b1;
    tick();
    check("t5_idle", {63'd0, bus.o_rsp_valid}, 64'd0);

    // Reset while holding a response; pointer returns to favour req0
    set_req(0, OP_ADD, 32'd9, 32'd9, 32'd0);
    bus.i_req_valid = 2'b01;
    bus.i_rsp_ready = 1'b0;
    tick();
    bus.i_req_valid = 2'b00;
    tick();
    check("t6_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd1);
    check("t6_rsp_data", {32'd0, bus.o_rsp_data}, 64'd18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", {63'd0, bus.o_rsp_valid}, 64'd0);
    check("t6_rst_data", {32'd0, bus.o_rsp_data}, 64'd0);
    check("t6_rst_alu_rs1", {32'd0, bus.o_alu_rs1}, 64'd0);
    check("t6_rst_ready", {62'd0, bus.o_req_ready}, 64'd0);
    set_req(0, OP_ADD, 32'd1, 32'd1, 32'd0);
    set_req(1, OP_ADD, 32'd2, 32'd2, 32'd0);
    bus.i_req_valid = 2'b11;
    bus.i_rsp_ready = 1'b1;
    #1 check("t6_tie_ready", {62'd0, bus.o_req_ready}, 64'd1);
    exp_q.push_back({1'b0, 32'd2});
    tick();
    bus.i_req_valid = 2'b00;
    tick();
    tick();
    tick();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational integer ALU between two requesters: req0 = main execute pipeline, req1 = auxiliary unit (address-gen/debug).
- Round-robin arbitration with a valid/ready handshake per requester.
- Latches the granted operation into an operand register that drives the ALU, captures the ALU result, and returns it on a shared tagged response channel with backpressure.

Parameters:
- DATA_WIDTH, 31, MSB index of operand/result data (data width = DATA_WIDTH+1); matches the ALU instance.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clk_en  input  1  clock enable; low = all state frozen.
- rst  input  1  synchronous, active-high reset.
- i_req_valid  input  2  bit k = requester k has an operation.
- o_req_ready  output  2  bit k = requester k accepted this cycle; at most one bit high.
- i_req_op  input  34  requester k at [17k+16:17k] = {opcode[6:0], funct7[6:0], funct3[2:0]}.
- i_req_rs1  input  2*(DATA_WIDTH+1)  requester k at slice k.
- i_req_rs2  input  2*(DATA_WIDTH+1)  requester k at slice k.
- i_req_imm  input  64  requester k at [32k+31:32k].
- o_rsp_valid  output  1  result available.
- o_rsp_id  output  1  requester index owning the result.
- o_rsp_data  output  DATA_WIDTH+1  result.
- i_rsp_ready  input  1  consumer accepts result.
- o_alu_op  output  17  {opcode, funct7, funct3} to ALU.
- o_alu_rs1, o_alu_rs2  output  DATA_WIDTH+1 each  operands to ALU.
- o_alu_imm  output  32  immediate to ALU.
- i_alu_rd_data  input  DATA_WIDTH+1  ALU result.

Behaviour:
- Three states:
  - IDLE: no operation held.
  - EXEC: operand register holds the op; ALU evaluating.
  - RESP: result register valid.
- Reset (rst high at an edge):
  - State -> IDLE; last_grant -> 1, so req0 wins the first tie.
  - Operand, result and id registers -> 0.
  - Outputs: o_req_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, all o_alu_*=0.
  - Reset mid-operation discards the in-flight op and result; rst overrides clk_en.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the index != last_grant.
  - last_grant updates only on an accept handshake.
- o_req_ready is combinational; the grant bit is asserted when clk_en=1 and either:
  - state=IDLE, or
  - state=RESP and i_rsp_ready=1 (back-to-back).
- o_req_ready=0 in EXEC or when clk_en=0.
- Accept = valid & ready. On accept:
  - Latch the granted op/rs1/rs2/imm into the operand register and the grant index into the id register.
  - State -> EXEC.
  - Requesters must hold inputs stable only during the accept cycle.
- o_alu_* always reflect the operand register (registered outputs).
- EXEC (clk_en=1): i_alu_rd_data -> result register; state -> RESP. Exactly one cycle.
- RESP:
  - o_rsp_valid=1; o_rsp_data and o_rsp_id stable until i_rsp_ready=1.
  - On response handshake with a new accept: -> EXEC.
  - On response handshake without a new accept: -> IDLE.
- Latency: accept in cycle c -> o_rsp_valid=1 in cycle c+2.
  - Peak throughput: one op per 2 cycles.
  - Zero-backpressure requester waits at most 2 ops under contention.
- clk_en=0:
  - No state, register or last_grant change.
  - o_rsp_valid/o_rsp_data held; ready forced 0.
  - A response handshake is not recognised while clk_en=0.
- Unsupported opcode/funct3: passed through unchanged; the ALU returns 0, which is reported normally.
- Requester dropping valid without handshake: legal; no side effects.

Test Plan:
- Only req0 valid, ADD (op 0110011/0000000/000) rs1=5, rs2=7, rsp_ready=1 -> o_req_ready=01 in cycle c; in cycle c+2 o_rsp_valid=1, data=12, id=0; IDLE at c+3.
- Both valid after reset: req0 SUB 10-3, req1 SRAI (0010011, funct7 0100000, 101) rs1=0x80000000, imm=4 -> req0 granted first (data=7, id=0); req1 next (data=0xF8000000, id=1).
- i_rsp_ready=0 for 5 cycles while in RESP, both requesters valid -> data/id held constant; o_req_ready=00 throughout; accept resumes the cycle rsp_ready rises.
- Both requesters permanently valid, rsp_ready=1 -> grants alternate 0,1,0,1; one response every 2 cycles; no starvation over 20 ops.
- clk_en=0 for 3 cycles while in EXEC -> state, o_alu_* and o_rsp_valid=0 unchanged; result appears 1 cycle after clk_en returns.
- rst pulse while in RESP with o_rsp_valid=1 -> o_rsp_valid=0 and all outputs 0 next cycle; the next tie grants req0.
